frame_readout_ctrl: RTL

Sequences the decoded-frame register bank (16 byte-wide addresses, combinational byte readout, frame `valid` flag) for the host/microcontroller side.
- On each new valid frame, walks the bank addresses and copies the 13 meaningful bytes into a local snapshot buffer.
- The host then drains the snapshot through a byte-wide strobe handshake with an auto-incrementing pointer, so a later frame cannot tear an in-progress read.
- Sits between the decoder/multiplex block and the chip's host pins.

---
 rtl/frame_readout_ctrl_pkg.sv | 33 +++
 rtl/frame_readout_ctrl_if.sv | 27 ++
 rtl/frame_snapshot_buf.sv | 30 +++
 rtl/frame_readout_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/frame_readout_ctrl_pkg.sv
// Shared definitions for the frame readout controller and its snapshot buffer.
// Holds the state encoding, slot count, the slot-to-bank-address map and the
// bank address constants that the decoder/multiplex block also uses.
package frame_readout_ctrl_pkg;

    localparam int unsigned NUM_SLOTS = 13;
    localparam logic [3:0]  LAST_SLOT = 4'(NUM_SLOTS - 1);
    localparam logic [3:0]  PARK_ADDR = 4'd15;

    // Bank layout of the decoded-frame register bank.
    localparam logic [3:0] ADDR_THERM_ID_FIRST  = 4'd0;
    localparam logic [3:0] ADDR_THERM_ID_LAST   = 4'd3;
    localparam logic [3:0] ADDR_ROOM_TEMP_FIRST = 4'd4;
    localparam logic [3:0] ADDR_ROOM_TEMP_LAST  = 4'd5;
    localparam logic [3:0] ADDR_SET_TEMP_FIRST  = 4'd6;
    localparam logic [3:0] ADDR_SET_TEMP_LAST   = 4'd7;
    localparam logic [3:0] ADDR_STATE           = 4'd8;
    localparam logic [3:0] ADDR_TAIL_FIRST      = 4'd9;
    localparam logic [3:0] ADDR_TAIL_LAST       = 4'd11;
    localparam logic [3:0] ADDR_VALIDATION      = 4'd15;

    typedef logic [1:0] state_t;

    localparam state_t StIdle    = 2'd0;
    localparam state_t StCapture = 2'd1;
    localparam state_t StReady   = 2'd2;

    // Slots 0..11 map straight onto the bank; the last slot holds the validation byte.
    function automatic logic [3:0] slot_addr(input logic [3:0] slot);
        return (slot < LAST_SLOT) ? slot : ADDR_VALIDATION;
    endfunction

endpackage

// File: rtl/frame_readout_ctrl_if.sv
// Bus between the readout controller, the multiplex block and the host pins.
//   master: the controller (drives mux_address and all host-facing outputs)
//   slave : the surrounding logic (drives frame_valid, mux_data and host strobes)
interface frame_readout_ctrl_if;

    logic       frame_valid;
    logic [3:0] mux_address;
    logic [7:0] mux_data;
    logic       host_read;
    logic       host_rewind;
    logic [7:0] host_data;
    logic       host_ready;
    logic [3:0] rd_ptr;
    logic       overrun;
    logic [3:0] frame_count;

    modport master (
        input  frame_valid, mux_data, host_read, host_rewind,
        output mux_address, host_data, host_ready, rd_ptr, overrun, frame_count
    );

    modport slave (
        output frame_valid, mux_data, host_read, host_rewind,
        input  mux_address, host_data, host_ready, rd_ptr, overrun, frame_count
    );

endinterface

// File: rtl/frame_snapshot_buf.sv
// 13 x 8 snapshot register file: one synchronous write port, one combinational
// read port. Contents are not reset; they are always rewritten before use.
//   clock   : system clock
//   wr_en   : write strobe
//   wr_slot : write slot 0..12
//   wr_data : write byte
//   rd_slot : read slot 0..12
//   rd_data : byte stored at rd_slot (0 for unreachable slots)
module frame_snapshot_buf
    import frame_readout_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       wr_en,
    input  logic [3:0] wr_slot,
    input  logic [7:0] wr_data,
    input  logic [3:0] rd_slot,
    output logic [7:0] rd_data
);

    logic [7:0] mem [NUM_SLOTS];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_slot] <= wr_data;
        end
    end

    assign rd_data = (rd_slot <= LAST_SLOT) ? mem[rd_slot] : 8'h00;

endmodule

// File: rtl/frame_readout_ctrl.sv
// Frame readout controller. On each rising edge of frame_valid it walks the
// decoded-frame bank and copies 13 bytes into a snapshot buffer, then lets the
// host drain the snapshot through a read/rewind strobe pair with an
// auto-incrementing pointer. Frames arriving while a snapshot is pending are
// dropped and flagged with the sticky overrun bit.
//   clock   : system clock
//   reset_n : asynchronous active-low reset
//   bus     : master side of frame_readout_ctrl_if (mux and host signals)
module frame_readout_ctrl
    import frame_readout_ctrl_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    frame_readout_ctrl_if.master bus
);

    state_t     state_q, state_d;
    logic       vld_q;
    logic       start;
    logic [3:0] slot_q, slot_d;
    logic [3:0] rd_ptr_q, rd_ptr_d;
    logic [3:0] frame_count_q, frame_count_d;
    logic       overrun_q, overrun_d;
    logic       buf_we;
    logic [7:0] buf_rdata;

    assign start = bus.frame_valid & ~vld_q;

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        rd_ptr_d      = rd_ptr_q;
        frame_count_d = frame_count_q;
        overrun_d     = overrun_q;
        buf_we        = 1'b0;

        // Rewind clears overrun in every state.
        if (bus.host_rewind) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StCapture;
                    slot_d  = 4'd0;
                end
            end
            StCapture: begin
                if (!bus.frame_valid) begin
                    state_d = StIdle;
                    slot_d  = 4'd0;
                end else begin
                    buf_we = 1'b1;
                    if (slot_q == LAST_SLOT) begin
                        state_d       = StReady;
                        slot_d        = 4'd0;
                        rd_ptr_d      = 4'd0;
                        frame_count_d = frame_count_q + 4'd1;
                    end else begin
                        slot_d = slot_q + 4'd1;
                    end
                end
            end
            StReady: begin
                // A new frame cannot overwrite an unread snapshot; losing it wins over rewind.
                if (start) begin
                    overrun_d = 1'b1;
                end
                if (bus.host_rewind) begin
                    rd_ptr_d = 4'd0;
                end else if (bus.host_read) begin
                    if (rd_ptr_q == LAST_SLOT) begin
                        rd_ptr_d = 4'd0;
                        state_d  = StIdle;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            vld_q         <= 1'b0;
            slot_q        <= 4'd0;
            rd_ptr_q      <= 4'd0;
            frame_count_q <= 4'd0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            vld_q         <= bus.frame_valid;
            slot_q        <= slot_d;
            rd_ptr_q      <= rd_ptr_d;
            frame_count_q <= frame_count_d;
            overrun_q     <= overrun_d;
        end
    end

    frame_snapshot_buf u_snapshot_buf (
        .clock   (clock),
        .wr_en   (buf_we),
        .wr_slot (slot_q),
        .wr_data (bus.mux_data),
        .rd_slot (rd_ptr_q),
        .rd_data (buf_rdata)
    );

    assign bus.mux_address = (state_q == StCapture) ? slot_addr(slot_q) : PARK_ADDR;
    assign bus.host_data   = (state_q == StReady) ? buf_rdata : 8'h00;
    assign bus.host_ready  = (state_q == StReady);
    assign bus.rd_ptr      = rd_ptr_q;
    assign bus.overrun     = overrun_q;
    assign bus.frame_count = frame_count_q;

endmodule
